transparency_blend_pipeline: RTL

Pipelined, multi-channel alpha blender with built-in fade engine, successor to the single-channel combinational transparency mixer. Sits in the pixel pipeline between the two source-fetch stages (A = overlay, B = background) and the VGA output register. It blends every channel of a packed pixel with exact end-points and rounding, and supports pass-through and chroma-key modes. Blend proportion can be loaded directly or ramped frame-by-frame toward a target.

---
 rtl/transparency_blend_pipeline.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/transparency_blend_pipeline.sv
// Pipelined multi-channel alpha blender with a frame-rate fade engine.
// Stage 1 forms per-channel weighted products, and stage 2 rounds and sums them.
// Pass-through and chroma-key modes are folded into the blend. They force the
// effective proportion to 0 or 2^P, and the end-points of the blend are exact.
module transparency_blend_pipeline #(
  parameter int CHANNEL_WIDTH          = 8,
  parameter int CHANNEL_COUNT          = 3,
  parameter int TRANSPARENCY_PRECISION = 4,
  parameter int FADE_DIV_LOG2          = 0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   pixel_valid_in,
  input  logic [CHANNEL_COUNT*CHANNEL_WIDTH-1:0] src_a_in,
  input  logic [CHANNEL_COUNT*CHANNEL_WIDTH-1:0] src_b_in,
  input  logic [1:0]                             mode_in,
  input  logic [CHANNEL_COUNT*CHANNEL_WIDTH-1:0] key_colour,
  input  logic                                   frame_tick,
  input  logic [TRANSPARENCY_PRECISION:0]        alpha_target,
  input  logic                                   alpha_load,
  input  logic                                   fade_start,
  output logic                                   pixel_valid_out,
  output logic [CHANNEL_COUNT*CHANNEL_WIDTH-1:0] pixel_out,
  output logic [TRANSPARENCY_PRECISION:0]        alpha_current,
  output logic                                   fading,
  output logic                                   fade_done
);

  localparam int W     = CHANNEL_WIDTH;
  localparam int C     = CHANNEL_COUNT;
  localparam int P     = TRANSPARENCY_PRECISION;
  localparam int PW    = P + 1;
  localparam int SW    = W + P + 1;
  localparam int DIV_W = FADE_DIV_LOG2 + 1;

  localparam logic [PW-1:0]    ALPHA_MAX = PW'(1) << P;
  localparam logic [SW-1:0]    ROUND     = SW'(1) << (P - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'((1 << FADE_DIV_LOG2) - 1);

  typedef enum logic {
    S_IDLE,
    S_FADING
  } fade_state_e;

  // Fade engine state
  fade_state_e      state_q;
  logic [PW-1:0]    alpha_q;
  logic [PW-1:0]    target_q;
  logic [DIV_W-1:0] div_q;
  logic             fade_done_q;

  // Pipeline state
  logic [C-1:0][SW-1:0] prod_a_d, prod_a_q;
  logic [C-1:0][SW-1:0] prod_b_d, prod_b_q;
  logic                 s1_valid_q;
  logic [C*W-1:0]       pixel_d, pixel_q;
  logic                 s2_valid_q;

  logic [PW-1:0] eff_alpha;
  logic [PW-1:0] inv_alpha;
  logic          key_match;
  logic [PW-1:0] target_clamped;
  logic [PW-1:0] alpha_step;

  assign key_match      = (src_b_in == key_colour);
  assign target_clamped = (alpha_target > ALPHA_MAX) ? ALPHA_MAX : alpha_target;
  assign alpha_step     = (target_q > alpha_q) ? alpha_q + PW'(1) : alpha_q - PW'(1);
  assign inv_alpha      = ALPHA_MAX - eff_alpha;

  // Mode selection. A pass-through value is a blend at an end-point proportion.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves eff_alpha unassigned (no latch).
    eff_alpha = alpha_q;
    case (mode_in)
      2'b01:   eff_alpha = ALPHA_MAX;
      2'b10:   eff_alpha = '0;
      2'b11:   eff_alpha = key_match ? ALPHA_MAX : '0;
      default: eff_alpha = alpha_q;
    endcase
  end

  // Per-channel weighted products for stage 1
  always_comb begin
    prod_a_d = '0;
    prod_b_d = '0;
    for (int c = 0; c < C; c++) begin
      prod_a_d[c] = SW'(eff_alpha) * SW'(src_a_in[c*W +: W]);
      prod_b_d[c] = SW'(inv_alpha) * SW'(src_b_in[c*W +: W]);
    end
  end

  // Rounded sum for stage 2. The result never exceeds 2^W-1, so truncating is safe.
  always_comb begin
    pixel_d = '0;
    for (int c = 0; c < C; c++) begin
      pixel_d[c*W +: W] = W'((prod_a_q[c] + prod_b_q[c] + ROUND) >> P);
    end
  end

  // Two-stage datapath registers. In-flight pixels are discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_a_q   <= '0;
      prod_b_q   <= '0;
      s1_valid_q <= 1'b0;
      pixel_q    <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
      prod_a_q   <= prod_a_d;
      prod_b_q   <= prod_b_d;
      s1_valid_q <= pixel_valid_in;
      pixel_q    <= pixel_d;
      s2_valid_q <= s1_valid_q;
    end
  end

  // Fade FSM. Priority is alpha_load, then fade_start, then frame_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      alpha_q     <= '0;
      target_q    <= '0;
      div_q       <= '0;
      fade_done_q <= 1'b0;
    end else begin
      fade_done_q <= 1'b0;
      if (alpha_load) begin
        alpha_q <= target_clamped;
        div_q   <= '0;
        state_q <= S_IDLE;
      end else if (fade_start) begin
        target_q <= target_clamped;
        div_q    <= '0;
        if (target_clamped == alpha_q) begin
          state_q     <= S_IDLE;
          fade_done_q <= 1'b1;
        end else begin
          state_q <= S_FADING;
        end
      end else if (state_q == S_FADING && frame_tick) begin
        if (div_q == DIV_LAST) begin
          div_q   <= '0;
          alpha_q <= alpha_step;
          if (alpha_step == target_q) begin
            state_q     <= S_IDLE;
            fade_done_q <= 1'b1;
          end
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end
    end
  end

  assign pixel_out       = pixel_q;
  assign pixel_valid_out = s2_valid_q;
  assign alpha_current   = alpha_q;
  assign fading          = (state_q == S_FADING);
  assign fade_done       = fade_done_q;

endmodule
